// File: rtl/scoreboard_pkg.sv
// Shared constants and types for the register scoreboard that tracks in-flight
// destination-register writes between decode and writeback.
package scoreboard_pkg;

  localparam int SB_ADDR_WIDTH = 5;
  localparam int SB_NUM_REGS   = 32;
  localparam int SB_CNT_WIDTH  = 2;
  localparam int SB_CNT_MAX    = 3;

  typedef logic [SB_CNT_WIDTH-1:0]  sb_cnt_t;
  typedef logic [SB_ADDR_WIDTH-1:0] sb_reg_t;

  // Largest value an in-flight counter of the given width can hold.
  function automatic int sb_cnt_max(input int width);
    return (1 << width) - 1;
  endfunction

endpackage

// File: rtl/sb_reg_counter.sv
// In-flight write counter for one architectural register: +1 on issue, -1 per
// writeback or squash, clamped at both ends with a one-cycle error pulse.
module sb_reg_counter
  import scoreboard_pkg::*;
#(
  parameter int CNT_WIDTH = SB_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 dec_w,
  input  logic                 dec_k,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 err_pulse
);

  localparam int             W       = CNT_WIDTH + 2;
  localparam logic [W-1:0]   MAX_EXT = W'(sb_cnt_max(CNT_WIDTH));

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic [W-1:0]         up;
  logic [W-1:0]         down;
  logic [W-1:0]         diff;

  // Two extra bits let the sum express both "below zero" and "above max".
  always_comb begin
    up        = {2'b00, cnt_q} + W'(inc);
    down      = W'(dec_w) + W'(dec_k);
    diff      = up - down;
    cnt_d     = cnt_q;
    err_pulse = 1'b0;
    if (down > up) begin
      cnt_d     = '0;
      err_pulse = 1'b1;
    end else if (diff > MAX_EXT) begin
      err_pulse = 1'b1;
    end else begin
      cnt_d = diff[CNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/register_scoreboard.sv
// Decode-side register scoreboard: per-register in-flight counters, busy lookup
// for rs1/rs2 and the decode stall. Optional SCOREBOARD_STATS_EN adds stall counters.
module register_scoreboard
  import scoreboard_pkg::*;
#(
  parameter int ADDR_WIDTH = SB_ADDR_WIDTH,
  parameter int NUM_REGS   = SB_NUM_REGS,
  parameter int CNT_WIDTH  = SB_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic                  issue_regwrite,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  input  logic                  rs1_used,
  input  logic                  rs2_used,
  input  logic [ADDR_WIDTH-1:0] w_rd,
  input  logic                  w_regwrite,
  input  logic                  kill_valid,
  input  logic [ADDR_WIDTH-1:0] kill_rd,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  stall,
  output logic                  sb_error
`ifdef SCOREBOARD_STATS_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           hazard_stalls
`endif
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(sb_cnt_max(CNT_WIDTH));

  logic [CNT_WIDTH-1:0] cnt [NUM_REGS];
  logic [NUM_REGS-1:0]  err_vec;
  logic                 issue_wr;
  logic                 issue_dec;
  logic                 full;
  logic                 sb_error_q;

  assign issue_wr = issue_valid & issue_regwrite;

  // x0 is hard-wired: never pending, never an error source.
  assign cnt[0]     = '0;
  assign err_vec[0] = 1'b0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
    localparam logic [ADDR_WIDTH-1:0] IDX = ADDR_WIDTH'(i);

    sb_reg_counter #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (issue_wr & ~stall & (issue_rd == IDX)),
      .dec_w     (w_regwrite & (w_rd == IDX)),
      .dec_k     (kill_valid & (kill_rd == IDX)),
      .cnt       (cnt[i]),
      .err_pulse (err_vec[i])
    );
  end

  // Pending writes that survive this cycle's writeback/squash; a same-cycle
  // writeback is covered by decode forwarding, so it does not count as busy.
  function automatic logic residue(input logic [CNT_WIDTH-1:0] c,
                                   input logic                 dw,
                                   input logic                 dk);
    logic [CNT_WIDTH:0] decs;
    decs = (CNT_WIDTH+1)'(dw) + (CNT_WIDTH+1)'(dk);
    return {1'b0, c} > decs;
  endfunction

  always_comb begin
    rs1_busy = residue(cnt[rs1], w_regwrite & (w_rd == rs1), kill_valid & (kill_rd == rs1))
               & (rs1 != '0);
    rs2_busy = residue(cnt[rs2], w_regwrite & (w_rd == rs2), kill_valid & (kill_rd == rs2))
               & (rs2 != '0);
    issue_dec = (w_regwrite & (w_rd == issue_rd)) | (kill_valid & (kill_rd == issue_rd));
    full      = issue_wr & (cnt[issue_rd] == CNT_MAX) & ~issue_dec;
    stall     = (rs1_busy & rs1_used) | (rs2_busy & rs2_used) | full;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_error_q <= 1'b0;
    end else if (|err_vec) begin
      sb_error_q <= 1'b1;
    end
  end

  assign sb_error = sb_error_q;

`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] hazard_stalls_q;
  logic        stall_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q  <= '0;
      hazard_stalls_q <= '0;
      stall_prev_q    <= 1'b0;
    end else begin
      stall_prev_q <= stall;
      if (stall) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (stall && !stall_prev_q) begin
        hazard_stalls_q <= hazard_stalls_q + 32'd1;
      end
    end
  end

  assign stall_cycles  = stall_cycles_q;
  assign hazard_stalls = hazard_stalls_q;
`endif

endmodule
